dmem_copy_dma: RTL and testbench

//  Initiator for the data-memory stall/handshake port: word-granular block-copy engine.

---
 rtl/dmem_copy_dma.sv | 153 +++++++++++++++
 tb/tb_dmem_copy_dma.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_copy_dma.sv
// Word-granular block-copy initiator for the data-memory stall/handshake port.
// Optional DMEM_COPY_DMA_FILL_EN adds a fill mode that writes a constant word to the destination range.
module dmem_copy_dma #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    input  logic             abort,
`ifdef DMEM_COPY_DMA_FILL_EN
    input  logic             fill,
    input  logic [31:0]      fill_value,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic [3:0]       mem_sign_mask,
    input  logic             mem_clk_stall,
    input  logic [31:0]      mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [31:0]      src_cur;
    logic [31:0]      dst_cur;
    logic [31:0]      word_reg;
    logic [31:0]      src_nx;
    logic [31:0]      dst_nx;
    logic [31:0]      word_nx;
    logic [31:0]      fill_word;
    logic [LEN_W-1:0] len_cur;
    logic [LEN_W-1:0] words_inc;
    logic             fill_mode;
    logic             start_fill;
    logic             misaligned;
    logic             accept;
    logic             word_done;

`ifdef DMEM_COPY_DMA_FILL_EN
    assign start_fill = fill;
    assign fill_word  = fill_value;
`else
    assign start_fill = 1'b0;
    assign fill_word  = '0;
`endif

    // Fill never reads, so only the destination alignment matters there.
    assign misaligned = start_fill ? (dst_addr[1:0] != 2'b00)
                                   : ((src_addr[1:0] | dst_addr[1:0]) != 2'b00);
    assign accept        = (state == IDLE) && start;
    assign words_inc     = words_done + 1'b1;
    assign word_done     = (state == WR_WAIT) && !mem_clk_stall;
    assign mem_sign_mask = 4'b0100;

    always_comb begin
        state_nx = state;
        src_nx   = src_cur;
        dst_nx   = dst_cur;
        word_nx  = word_reg;
        unique case (state)
            IDLE: begin
                if (start) begin
                    src_nx  = src_addr;
                    dst_nx  = dst_addr;
                    word_nx = fill_word;
                    if ((len_words == '0) || misaligned) state_nx = DONE;
                    else if (start_fill)                 state_nx = WR_ISSUE;
                    else                                 state_nx = RD_ISSUE;
                end
            end
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT: begin
                if (!mem_clk_stall) begin
                    word_nx  = mem_read_data;
                    state_nx = WR_ISSUE;
                end
            end
            WR_ISSUE: state_nx = WR_WAIT;
            WR_WAIT: begin
                if (!mem_clk_stall) begin
                    src_nx = src_cur + 32'd4;
                    dst_nx = dst_cur + 32'd4;
                    if ((words_inc == len_cur) || abort) state_nx = DONE;
                    else if (fill_mode)                  state_nx = WR_ISSUE;
                    else                                 state_nx = RD_ISSUE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Request outputs are registered from the next state so they are high during the ISSUE cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_cur        <= '0;
            dst_cur        <= '0;
            word_reg       <= '0;
            len_cur        <= '0;
            fill_mode      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            words_done     <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
        end else begin
            src_cur      <= src_nx;
            dst_cur      <= dst_nx;
            word_reg     <= word_nx;
            busy         <= (state_nx != IDLE);
            done         <= (state == DONE);
            mem_memread  <= (state_nx == RD_ISSUE);
            mem_memwrite <= (state_nx == WR_ISSUE);
            if (state_nx == RD_ISSUE)      mem_addr <= src_nx;
            else if (state_nx == WR_ISSUE) mem_addr <= dst_nx;
            if (state_nx == WR_ISSUE) mem_write_data <= word_nx;
            if (accept) begin
                len_cur    <= len_words;
                fill_mode  <= start_fill;
                err        <= misaligned;
                words_done <= '0;
            end else if (word_done) begin
                words_done <= words_inc;
            end
        end
    end

endmodule

// File: tb/tb_dmem_copy_dma.sv
// Self-checking bench for dmem_copy_dma: stall/handshake responder with backing memory,
// table-driven corner cases, randomized transfers against a word-level copy model.
module tb_dmem_copy_dma;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy, done, err, mem_memread, mem_memwrite;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      mem_addr, mem_write_data;
    logic [3:0]       mem_sign_mask;
    logic             mem_clk_stall = 1'b0;
    logic [31:0]      mem_read_data = '0;
`ifdef DMEM_COPY_DMA_FILL_EN
    logic             fill = 1'b0;
    logic [31:0]      fill_value = '0;
`endif

    always #5 clk = ~clk;

    dmem_copy_dma #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len_words(len_words), .abort(abort),
`ifdef DMEM_COPY_DMA_FILL_EN
        .fill(fill), .fill_value(fill_value),
`endif
        .busy(busy), .done(done), .err(err), .words_done(words_done), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_sign_mask(mem_sign_mask), .mem_clk_stall(mem_clk_stall), .mem_read_data(mem_read_data)
    );

    logic [31:0] mem [4096];
    logic [31:0] ref_mem [4096];
    int unsigned rd_cnt = 0, wr_cnt = 0, proto_err = 0, resp_left = 0;
    bit          preload_go = 1'b0;
    logic [31:0] preload_seed = '0;

    function automatic int unsigned idx(input logic [31:0] a);
        return 32'(a[13:2]);
    endfunction

    // Responder: request sampled at an edge, stall for two cycles, released in the third.
    always @(posedge clk) begin
        if (preload_go) begin
            for (int unsigned i = 0; i < 4096; i++) mem[i] = preload_seed ^ (i * 32'h9E3779B9);
            for (int unsigned k = 0; k < 4; k++) mem[idx(32'h1000) + k] = 32'hA0 + k;
        end
        if (mem_memread || mem_memwrite) begin
            if (resp_left != 0 || mem_clk_stall || (mem_memread && mem_memwrite)) proto_err++;
            if (mem_memread) begin
                mem_read_data <= mem[idx(mem_addr)];
                rd_cnt++;
            end
            if (mem_memwrite) begin
                mem[idx(mem_addr)] = mem_write_data;
                wr_cnt++;
            end
            resp_left = 2;
            mem_clk_stall <= 1'b1;
        end else if (resp_left != 0) begin
            if (resp_left == 1) mem_clk_stall <= 1'b0;
            resp_left--;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        bit          fill;
        logic [31:0] fval;
        int          abort_w;
        bit          restart;
        bit          exp_err;
        int          exp_words;
        int          exp_cyc;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] s, input logic [31:0] d,
                                input int l, input bit f, input logic [31:0] fv, input int ab,
                                input bit rs, input bit e, input int w, input int c);
        vec_t v;
        v.name = n; v.src = s; v.dst = d; v.len = l; v.fill = f; v.fval = fv;
        v.abort_w = ab; v.restart = rs; v.exp_err = e; v.exp_words = w; v.exp_cyc = c;
        return v;
    endfunction

    task automatic preload(input logic [31:0] seed);
        @(negedge clk);
        preload_seed = seed;
        preload_go   = 1'b1;
        @(negedge clk);
        preload_go = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc, n_m, diffs;
        bit          seen, err_m;
        int unsigned rd0, wr0, pe0;
        rd0 = rd_cnt; wr0 = wr_cnt; pe0 = proto_err;
        // Reference: sequential ascending word copy (or fill) over the accepted range.
        err_m = v.fill ? (v.dst[1:0] != 2'b00) : ((v.src[1:0] | v.dst[1:0]) != 2'b00);
        if (err_m || v.len == 0)                     n_m = 0;
        else if (v.abort_w >= 0 && v.abort_w + 1 < v.len) n_m = v.abort_w + 1;
        else                                         n_m = v.len;
        for (int i = 0; i < n_m; i++)
            ref_mem[idx(v.dst + 32'(4 * i))] = v.fill ? v.fval : ref_mem[idx(v.src + 32'(4 * i))];

        @(negedge clk);
        src_addr  = v.src;
        dst_addr  = v.dst;
        len_words = v.len[LEN_W-1:0];
`ifdef DMEM_COPY_DMA_FILL_EN
        fill       = v.fill;
        fill_value = v.fval;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (cyc < 1000) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (v.abort_w >= 0 && int'(words_done) == v.abort_w) abort = 1'b1;
            if (v.restart && cyc == 5) begin
                start = 1'b1; src_addr = 32'h0; dst_addr = 32'h3000; len_words = 1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        abort = 1'b0;
        start = 1'b0;
        check({v.name, ".done_seen"}, 64'(seen), 64'd1);
        check({v.name, ".done_cycle"}, 64'(cyc), 64'(v.exp_cyc));
        check({v.name, ".err"}, 64'(err), 64'(v.exp_err));
        check({v.name, ".words_done"}, 64'(words_done), 64'(v.exp_words));
        check({v.name, ".busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({v.name, ".done_pulse"}, 64'(done), 64'd0);
        check({v.name, ".err_sticky"}, 64'(err), 64'(v.exp_err));
        check({v.name, ".reads"}, 64'(rd_cnt - rd0), 64'(v.fill ? 0 : n_m));
        check({v.name, ".writes"}, 64'(wr_cnt - wr0), 64'(n_m));
        check({v.name, ".protocol"}, 64'(proto_err - pe0), 64'd0);
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check({v.name, ".mem"}, 64'(diffs), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[$];
        vec_t v;
        //          name       src           dst           len fill fval           abrt rs err wds cyc
        tab.push_back(mk("copy4",   32'h1000,     32'h1100,     4, 0, 32'h0,         -1, 0, 0, 4, 34));
        tab.push_back(mk("len0",    32'h1000,     32'h1100,     0, 0, 32'h0,         -1, 0, 0, 0, 2));
        tab.push_back(mk("mis_src", 32'h1002,     32'h1100,     4, 0, 32'h0,         -1, 0, 1, 0, 2));
        tab.push_back(mk("realign", 32'h1000,     32'h1100,     1, 0, 32'h0,         -1, 0, 0, 1, 10));
        tab.push_back(mk("mis_dst", 32'h1000,     32'h1101,     2, 0, 32'h0,         -1, 0, 1, 0, 2));
        tab.push_back(mk("abort2",  32'h1400,     32'h1600,     8, 0, 32'h0,          1, 0, 0, 2, 18));
        tab.push_back(mk("restart", 32'h1800,     32'h1A00,     3, 0, 32'h0,         -1, 1, 0, 3, 26));
        tab.push_back(mk("wrap",    32'hFFFFFFF8, 32'h2000,     4, 0, 32'h0,         -1, 0, 0, 4, 34));
        tab.push_back(mk("overlap", 32'h1000,     32'h1004,     3, 0, 32'h0,         -1, 0, 0, 3, 26));
`ifdef DMEM_COPY_DMA_FILL_EN
        tab.push_back(mk("fill3",   32'h1000,     32'h1200,     3, 1, 32'hDEADBEEF,  -1, 0, 0, 3, 14));
        tab.push_back(mk("fill_src_ignored", 32'h1003, 32'h1300, 2, 1, 32'h12345678, -1, 0, 0, 2, 10));
`endif

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.outputs",
              64'({busy, done, err, words_done, mem_addr, mem_memread, mem_memwrite}), 64'd0);
        check("reset.write_data", 64'(mem_write_data), 64'd0);
        check("reset.sign_mask", 64'(mem_sign_mask), 64'h4);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tab[i]) begin
            preload(32'h5A5A0000 + 32'(i));
            run_vec(tab[i]);
        end

        for (int r = 0; r < 12; r++) begin
            int w;
            v.name    = $sformatf("rand%0d", r);
            v.src     = $urandom & 32'h3FFC;
            v.dst     = $urandom & 32'h3FFC;
            if ($urandom_range(0, 5) == 0) v.src[1] = 1'b1;
            v.len     = int'($urandom_range(1, 6));
            v.fill    = 1'b0;
            v.fval    = '0;
            v.abort_w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, v.len - 1)) : -1;
            v.restart = 1'b0;
            v.exp_err = (v.src[1:0] | v.dst[1:0]) != 2'b00;
            w = v.exp_err ? 0 : ((v.abort_w >= 0 && v.abort_w + 1 < v.len) ? v.abort_w + 1 : v.len);
            v.exp_words = w;
            v.exp_cyc   = 8 * w + 2;
            preload($urandom);
            run_vec(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
